// File: rtl/stopwatch_disp_pkg.sv
// rtl/stopwatch_disp_pkg.sv - shared types, constants and BCD helper for stopwatch_display
package stopwatch_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [2:0] DIG_CS0  = 3'd0;
    localparam logic [2:0] DIG_CS1  = 3'd1;
    localparam logic [2:0] DIG_SEC0 = 3'd2;
    localparam logic [2:0] DIG_SEC1 = 3'd3;
    localparam logic [2:0] DIG_MIN0 = 3'd4;
    localparam logic [2:0] DIG_MIN1 = 3'd5;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [5:0] MAX_MIN_SEC = 6'd59;
    localparam logic [6:0] MAX_CS      = 7'd99;

    // One double-dabble step on {tens[3:0], ones[3:0], bin[6:0]}: add-3 correction, then shift.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decoder.sv
// rtl/stopwatch_display_seg7_decoder.sv - BCD digit to active-low 7-segment code
module seg7_decoder
    import stopwatch_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Codes 10..15 cannot be produced by the converter; they blank the digit.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - MM.SS.CC multiplexed 7-segment driver; optional LAP_DP_EN lap marker
module stopwatch_display
    import stopwatch_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       m_clk,
    input  logic       reset,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [6:0] m_seconds,
    input  logic [1:0] showMode,
    input  logic       disp_en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] pre_cnt;
    logic [2:0]    idx;
    logic          tick;
    logic          boundary;
    state_t        state;
    logic [2:0]    iter;
    logic [14:0]   sh_min;
    logic [14:0]   sh_sec;
    logic [14:0]   sh_cs;
    logic [3:0]    dig [6];
    logic [5:0]    min_c;
    logic [5:0]    sec_c;
    logic [6:0]    cs_c;
    logic [6:0]    seg_next;
    logic          dp_low;

    assign tick     = (pre_cnt == CW'(SCAN_DIV - 1));
    assign boundary = tick && (idx == DIG_MIN1);

    assign min_c = (minutes   > MAX_MIN_SEC) ? MAX_MIN_SEC : minutes;
    assign sec_c = (seconds   > MAX_MIN_SEC) ? MAX_MIN_SEC : seconds;
    assign cs_c  = (m_seconds > MAX_CS)      ? MAX_CS      : m_seconds;

`ifdef LAP_DP_EN
    logic [1:0] lap_snap;
    assign dp_low = (idx == DIG_SEC0) || (idx == DIG_MIN0)
                 || ((lap_snap == 2'd1) && (idx == DIG_CS0))
                 || ((lap_snap == 2'd2) && (idx == DIG_CS1));
`else
    logic unused_show_mode;
    assign unused_show_mode = ^showMode;
    assign dp_low = (idx == DIG_SEC0) || (idx == DIG_MIN0);
`endif

    // Prescaler and digit index: one slot per SCAN_DIV cycles, six slots per frame.
    always_ff @(posedge m_clk) begin
        if (!reset) begin
            pre_cnt <= '0;
            idx     <= DIG_CS0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) idx <= (idx == DIG_MIN1) ? DIG_CS0 : idx + 3'd1;
        end
    end

    // Snapshot at the frame boundary, convert all fields in parallel, then load the digits.
    always_ff @(posedge m_clk) begin
        if (!reset) begin
            state      <= IDLE;
            iter       <= '0;
            sh_min     <= '0;
            sh_sec     <= '0;
            sh_cs      <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < 6; i++) dig[i] <= '0;
`ifdef LAP_DP_EN
            lap_snap   <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    iter       <= '0;
                    if (boundary) begin
                        sh_min <= {9'd0, min_c};
                        sh_sec <= {9'd0, sec_c};
                        sh_cs  <= {8'd0, cs_c};
`ifdef LAP_DP_EN
                        lap_snap <= showMode;
`endif
                        state  <= CONV;
                    end
                end
                CONV: begin
                    sh_min <= dd_step(sh_min);
                    sh_sec <= dd_step(sh_sec);
                    sh_cs  <= dd_step(sh_cs);
                    if (iter == 3'd6) begin
                        frame_done <= 1'b1;
                        state      <= LOAD;
                    end else begin
                        iter <= iter + 3'd1;
                    end
                end
                LOAD: begin
                    dig[DIG_CS0]  <= sh_cs[10:7];
                    dig[DIG_CS1]  <= sh_cs[14:11];
                    dig[DIG_SEC0] <= sh_sec[10:7];
                    dig[DIG_SEC1] <= sh_sec[14:11];
                    dig[DIG_MIN0] <= sh_min[10:7];
                    dig[DIG_MIN1] <= sh_min[14:11];
                    frame_done    <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    seg7_decoder u_dec (
        .bcd (dig[idx]),
        .seg (seg_next)
    );

    // Registered pin drivers; disp_en only gates the anodes.
    always_ff @(posedge m_clk) begin
        if (!reset) begin
            an  <= 6'b111111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= disp_en ? ~(6'b000001 << idx) : 6'b111111;
            seg <= seg_next;
            dp  <= ~dp_low;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - randomized model-checked bench for stopwatch_display
module tb_stopwatch_display;

    localparam int D = 10;
    localparam int FRAME = 6 * D;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] minutes = '0;
    logic [5:0] seconds = '0;
    logic [6:0] m_seconds = '0;
    logic [1:0] showMode = '0;
    logic       disp_en = 1'b1;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    stopwatch_display #(.SCAN_DIV(D)) dut (
        .m_clk      (clk),
        .reset      (reset),
        .minutes    (minutes),
        .seconds    (seconds),
        .m_seconds  (m_seconds),
        .showMode   (showMode),
        .disp_en    (disp_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] CODES [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: edges since reset decide the scan position; each capture lands 8 edges later.
    int         e;
    int         ip;
    int         pend_due;
    bit         pend_valid;
    int         digits [6];
    int         pend [6];
    int         lap_m;
    bit         chk_en = 0;
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fd;

    function automatic bit lap_dp(input int m, input int i);
`ifdef LAP_DP_EN
        return (m == 1 && i == 0) || (m == 2 && i == 1);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            e = 0;
            pend_valid = 0;
            lap_m = 0;
            for (int i = 0; i < 6; i++) digits[i] = 0;
            exp_an = 6'h3F;
            exp_seg = 7'h7F;
            exp_dp = 1'b1;
            exp_fd = 1'b0;
        end else begin
            int mm, ss, cc;
            ip = (e / D) % 6;
            exp_an  = disp_en ? ~(6'b000001 << ip) : 6'h3F;
            exp_seg = CODES[digits[ip]];
            exp_dp  = !(ip == 2 || ip == 4 || lap_dp(lap_m, ip));
            e++;
            if (pend_valid && e == pend_due) begin
                for (int i = 0; i < 6; i++) digits[i] = pend[i];
                pend_valid = 0;
            end
            exp_fd = pend_valid && (e == pend_due - 1);
            if (e % FRAME == 0) begin
                mm = (minutes > 59) ? 59 : int'(minutes);
                ss = (seconds > 59) ? 59 : int'(seconds);
                cc = (m_seconds > 99) ? 99 : int'(m_seconds);
                pend[0] = cc % 10; pend[1] = cc / 10;
                pend[2] = ss % 10; pend[3] = ss / 10;
                pend[4] = mm % 10; pend[5] = mm / 10;
                pend_due = e + 8;
                pend_valid = 1;
                lap_m = int'(showMode);
            end
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("an", {26'd0, an}, {26'd0, exp_an});
            chk("seg", {25'd0, seg}, {25'd0, exp_seg});
            chk("dp", {31'd0, dp}, {31'd0, exp_dp});
            chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
        end
    end

    logic [6:0] seg_seen [6];
    logic       dp_seen [6];

    task automatic scan(input int n);
        for (int i = 0; i < 6; i++) begin
            seg_seen[i] = 7'h7F;
            dp_seen[i] = 1'bx;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++)
                if (an == ~(6'b000001 << i)) begin
                    seg_seen[i] = seg;
                    dp_seen[i] = dp;
                end
        end
    endtask

    task automatic wait_fd(input int bound);
        bit got;
        got = 0;
        for (int k = 0; k < bound && !got; k++) begin
            @(negedge clk);
            if (frame_done) got = 1;
        end
        if (!got) chk("frame_done_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        bit got, seen_fd;
        // reset held three cycles
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_an", {26'd0, an}, 32'h3F);
            chk("rst_seg", {25'd0, seg}, 32'h7F);
        end
        minutes = 6'd12; seconds = 6'd34; m_seconds = 7'd56;
        reset = 1'b1;
        chk("rel_an", {26'd0, an}, 32'h3F);
        chk("rel_fd", {31'd0, frame_done}, 32'h0);

        // first frame_done: boundary at edge 60, visible 8 cycles after that tick cycle
        lat = 0; got = 0;
        while (!got && lat < 200) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (frame_done) got = 1;
        end
        chk("fd_latency", lat, 67);
        scan(60);
        chk("d5_1", {25'd0, seg_seen[5]}, {25'd0, 7'b1111001});
        chk("d4_2", {25'd0, seg_seen[4]}, {25'd0, 7'b0100100});
        chk("d3_3", {25'd0, seg_seen[3]}, {25'd0, 7'b0110000});
        chk("d2_4", {25'd0, seg_seen[2]}, {25'd0, 7'b0011001});
        chk("d1_5", {25'd0, seg_seen[1]}, {25'd0, 7'b0010010});
        chk("d0_6", {25'd0, seg_seen[0]}, {25'd0, 7'b0000010});
        for (int i = 0; i < 6; i++)
            chk("dp_sep", {31'd0, dp_seen[i]}, (i == 2 || i == 4) ? 32'd0 : 32'd1);

        // clamping
        minutes = 6'd63; seconds = 6'd60; m_seconds = 7'd120;
        wait_fd(200); wait_fd(200);
        scan(60);
        chk("clamp_d5", {25'd0, seg_seen[5]}, {25'd0, 7'b0010010});
        chk("clamp_d0", {25'd0, seg_seen[0]}, {25'd0, 7'b0010000});

        // no tearing: change inputs 3 cycles after a boundary
        minutes = 6'd1; seconds = 6'd2; m_seconds = 7'd3;
        wait_fd(200); wait_fd(200);
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (e % FRAME == 3) got = 1;
        end
        minutes = 6'd45; seconds = 6'd45; m_seconds = 7'd45;
        repeat (20) @(negedge clk);
        chk("tear_hold", {25'd0, seg}, {25'd0, CODES[digits[(e - 1) / D % 6]]});
        wait_fd(200);
        scan(60);
        chk("tear_new", {25'd0, seg_seen[5]}, {25'd0, 7'b0011001});

        // reset during conversion
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (e % FRAME == 2) got = 1;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_an", {26'd0, an}, 32'h3F);
        reset = 1'b1;
        seen_fd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (frame_done) seen_fd = 1;
        end
        chk("midrst_no_fd", {31'd0, seen_fd}, 32'd0);
        chk("midrst_zero", {25'd0, seg}, {25'd0, 7'b1000000});

        // disp_en gating
        repeat (13) @(negedge clk);
        disp_en = 1'b0;
        @(negedge clk);
        chk("dis_an", {26'd0, an}, 32'h3F);
        repeat (4) @(negedge clk);
        disp_en = 1'b1;
        @(negedge clk);
        chk("reen_an", {26'd0, an}, {26'd0, ~(6'b000001 << ((e - 1) / D % 6))});

        // lap marker
        showMode = 2'd2;
        wait_fd(200); wait_fd(200);
        scan(60);
`ifdef LAP_DP_EN
        chk("lap2_dp1", {31'd0, dp_seen[1]}, 32'd0);
`else
        chk("lap2_dp1", {31'd0, dp_seen[1]}, 32'd1);
`endif
        chk("lap2_dp0", {31'd0, dp_seen[0]}, 32'd1);
        chk("lap2_dp2", {31'd0, dp_seen[2]}, 32'd0);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                minutes = 6'($urandom_range(0, 63));
                seconds = 6'($urandom_range(0, 63));
                m_seconds = 7'($urandom_range(0, 127));
            end
            if ($urandom_range(0, 29) == 0) disp_en = ~disp_en;
            if ($urandom_range(0, 99) == 0) showMode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) reset = 1'b0;
            else reset = 1'b1;
        end
        reset = 1'b1;
        disp_en = 1'b1;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
